vga_scan_generator: RTL and testbench

Raster timing and pixel-fetch stage for the 640x480 VGA path. It runs from the single system clock and derives a pixel tick internally, so no divided clock is needed. On each tick it advances the horizontal and vertical counters, drives the read address into the video RAM, and takes the 3-bit RGB word the RAM returns. It then outputs blank-gated RGB together with HSYNC/VSYNC, delayed so all three stay aligned.

---
 rtl/vga_scan_generator.sv | 123 ++++++++++++
 tb/tb_vga_scan_generator.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_generator.sv
// rtl/vga_scan_generator.sv - VGA raster timing, video RAM address generation and blank-gated RGB output
// Optional frame-start strobe on oFrameStart when VGA_FRAME_PULSE_EN is defined.
module vga_scan_generator #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int ADDR_W   = 24
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iEnable,
    input  logic [2:0]        iVmemData,
    output logic [ADDR_W-1:0] oVmemAddress,
    output logic              oPixelTick,
    output logic [2:0]        oRGB,
    output logic              oHS,
    output logic              oVS,
    output logic              oVideoActive,
    output logic              oFrameStart
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0]   H_LAST     = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]   H_ACT_END  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0]   H_SYNC_BEG = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0]   H_SYNC_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0]   V_LAST     = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]   V_ACT_END  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0]   V_SYNC_BEG = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0]   V_SYNC_END = V_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] divCount;
    logic [H_W-1:0]   hCount;
    logic [V_W-1:0]   vCount;
    logic             tick;
    logic             hWrap;
    logic             vWrap;
    logic             active;
    logic             hsN;
    logic             vsN;

    assign tick       = iEnable && (divCount == DIV_LAST);
    assign hWrap      = (hCount == H_LAST);
    assign vWrap      = (vCount == V_LAST);
    assign active     = (hCount < H_ACT_END) && (vCount < V_ACT_END);
    assign hsN        = !((hCount >= H_SYNC_BEG) && (hCount < H_SYNC_END));
    assign vsN        = !((vCount >= V_SYNC_BEG) && (vCount < V_SYNC_END));
    assign oPixelTick = tick;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            divCount <= '0;
        end else if (iEnable) begin
            divCount <= (divCount == DIV_LAST) ? '0 : divCount + DIV_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            hCount <= '0;
            vCount <= '0;
        end else if (tick) begin
            hCount <= hWrap ? '0 : hCount + H_W'(1);
            if (hWrap) begin
                vCount <= vWrap ? '0 : vCount + V_W'(1);
            end
        end
    end

    // Advancing only on visible pixels leaves the next line's first address
    // parked through hblank and H_ACTIVE*V_ACTIVE through vblank.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oVmemAddress <= '0;
        end else if (tick) begin
            if (hWrap && vWrap) begin
                oVmemAddress <= '0;
            end else if (active) begin
                oVmemAddress <= oVmemAddress + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oRGB         <= '0;
            oHS          <= 1'b1;
            oVS          <= 1'b1;
            oVideoActive <= 1'b0;
        end else if (tick) begin
            oRGB         <= active ? iVmemData : 3'b000;
            oHS          <= hsN;
            oVS          <= vsN;
            oVideoActive <= active;
        end
    end

`ifdef VGA_FRAME_PULSE_EN
    localparam logic [V_W-1:0] V_ACT_LAST = V_W'(V_ACTIVE - 1);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oFrameStart <= 1'b0;
        end else begin
            oFrameStart <= tick && hWrap && (vCount == V_ACT_LAST);
        end
    end
`else
    assign oFrameStart = 1'b0;
`endif

endmodule

// File: tb/tb_vga_scan_generator.sv
// tb/tb_vga_scan_generator.sv - self-checking bench for vga_scan_generator on a reduced raster
module tb_vga_scan_generator;
    localparam int CLK_DIV  = 3;
    localparam int H_ACTIVE = 64;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 8;
    localparam int H_BP     = 4;
    localparam int V_ACTIVE = 12;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int ADDR_W   = 16;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam int MEM_SIZE = 1024;
    localparam int VEC_W    = ADDR_W + 8;
    localparam int FREEZE_H = 20;

    logic              Clock = 1'b0;
    logic              Reset = 1'b0;
    logic              iEnable = 1'b1;
    logic [2:0]        iVmemData;
    logic [ADDR_W-1:0] oVmemAddress;
    logic              oPixelTick;
    logic [2:0]        oRGB;
    logic              oHS;
    logic              oVS;
    logic              oVideoActive;
    logic              oFrameStart;

    logic [2:0]        vmem [MEM_SIZE];
    logic [2:0]        vmemQ = 3'b000;
    logic              constMode = 1'b0;
    logic [VEC_W-1:0]  outVec;
    logic [VEC_W-1:0]  resetVec;

    int compared = 0;
    int mismatched = 0;
    int enClk = 0;
    int pos = 0;
    logic lastTick = 1'b0;

    vga_scan_generator #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .ADDR_W(ADDR_W)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .iEnable(iEnable),
        .iVmemData(iVmemData),
        .oVmemAddress(oVmemAddress),
        .oPixelTick(oPixelTick),
        .oRGB(oRGB),
        .oHS(oHS),
        .oVS(oVS),
        .oVideoActive(oVideoActive),
        .oFrameStart(oFrameStart)
    );

    always #5 Clock = ~Clock;

    // One-clock synchronous video RAM
    always @(posedge Clock) vmemQ <= vmem[int'(oVmemAddress) % MEM_SIZE];
    assign iVmemData = constMode ? 3'b101 : vmemQ;

    assign outVec   = {oVmemAddress, oRGB, oHS, oVS, oVideoActive, oPixelTick, oFrameStart};
    assign resetVec = {{ADDR_W{1'b0}}, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reference: pos is the raster position reached after counting enabled pixel periods
    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            enClk    <= 0;
            pos      <= 0;
            lastTick <= 1'b0;
        end else if (iEnable) begin
            enClk    <= enClk + 1;
            lastTick <= (enClk % CLK_DIV == CLK_DIV - 1);
            if (enClk % CLK_DIV == CLK_DIV - 1) pos <= (pos + 1) % FRAME;
        end else begin
            lastTick <= 1'b0;
        end
    end

    function automatic logic isActive(input int p);
        return ((p % H_TOTAL) < H_ACTIVE) && ((p / H_TOTAL) < V_ACTIVE);
    endfunction

    function automatic logic hsLevel(input int p);
        int h = p % H_TOTAL;
        return !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
    endfunction

    function automatic logic vsLevel(input int p);
        int v = p / H_TOTAL;
        return !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
    endfunction

    function automatic int addrOf(input int p);
        int h = p % H_TOTAL;
        int v = p / H_TOTAL;
        if (v >= V_ACTIVE) return H_ACTIVE * V_ACTIVE;
        if (h < H_ACTIVE) return v * H_ACTIVE + h;
        return (v + 1) * H_ACTIVE;
    endfunction

    function automatic logic [VEC_W-1:0] expVec();
        int prev = (pos + FRAME - 1) % FRAME;
        logic [2:0] rgb = isActive(prev) ? vmem[addrOf(prev)] : 3'b000;
        logic tk = iEnable && (enClk % CLK_DIV == CLK_DIV - 1);
        logic fs;
`ifdef VGA_FRAME_PULSE_EN
        fs = lastTick && (pos == V_ACTIVE * H_TOTAL);
`else
        fs = 1'b0;
`endif
        return {ADDR_W'(addrOf(pos)), rgb, hsLevel(prev), vsLevel(prev), isActive(prev), tk, fs};
    endfunction

    task automatic test_reset();
        Reset = 1'b0;
        iEnable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            compared++;
            if (outVec !== resetVec) begin
                mismatched++;
                $display("FAIL reset_hold: got %h expected %h", outVec, resetVec);
            end
        end
        Reset = 1'b1;
        for (int k = 1; k <= CLK_DIV; k++) begin
            logic [ADDR_W:0] want;
            @(negedge Clock);
            want = {(k == CLK_DIV - 1) ? 1'b1 : 1'b0, (k == CLK_DIV) ? ADDR_W'(1) : ADDR_W'(0)};
            compared++;
            if ({oPixelTick, oVmemAddress} !== want) begin
                mismatched++;
                $display("FAIL first_tick clk%0d: got %h expected %h", k, {oPixelTick, oVmemAddress}, want);
            end
        end
    endtask

    task automatic test_frame(input int nClk, input bit randEn);
        int clk = 0, lastVsFall = -1, hsLow = 0, vsLow = 0, actRun = 0;
        bit hsArm = 0, vsArm = 0, actArm = 0;
        logic prevVs = 1'b0;
        logic [VEC_W-1:0] want;
        for (int i = 0; i < nClk; i++) begin
            @(negedge Clock);
            clk++;
            want = expVec();
            compared++;
            if (outVec !== want) begin
                mismatched++;
                $display("FAIL frame_outputs pos=%0d: got %h expected %h", pos, outVec, want);
            end
            if (lastTick) begin
                if (oHS) begin
                    if (hsArm && hsLow > 0) begin
                        compared++;
                        if (hsLow != H_SYNC) begin
                            mismatched++;
                            $display("FAIL hsync_width: got %0d expected %0d", hsLow, H_SYNC);
                        end
                    end
                    hsLow = 0;
                    hsArm = 1;
                end else if (hsArm) begin
                    if (hsLow == 0) begin
                        compared++;
                        if ((pos + FRAME - 1) % H_TOTAL != H_ACTIVE + H_FP) begin
                            mismatched++;
                            $display("FAIL hsync_fall_h: got %0d expected %0d", (pos + FRAME - 1) % H_TOTAL, H_ACTIVE + H_FP);
                        end
                    end
                    hsLow++;
                end
                if (oVS) begin
                    if (vsArm && vsLow > 0) begin
                        compared++;
                        if (vsLow != V_SYNC * H_TOTAL) begin
                            mismatched++;
                            $display("FAIL vsync_width: got %0d expected %0d", vsLow, V_SYNC * H_TOTAL);
                        end
                    end
                    vsLow = 0;
                    vsArm = 1;
                end else if (vsArm) begin
                    vsLow++;
                end
                if (!oVideoActive) begin
                    if (actArm && actRun > 0) begin
                        compared++;
                        if (actRun != H_ACTIVE) begin
                            mismatched++;
                            $display("FAIL active_width: got %0d expected %0d", actRun, H_ACTIVE);
                        end
                    end
                    actRun = 0;
                    actArm = 1;
                end else if (actArm) begin
                    actRun++;
                end
            end
            if (!randEn && prevVs && !oVS) begin
                if (lastVsFall >= 0) begin
                    compared++;
                    if (clk - lastVsFall != FRAME * CLK_DIV) begin
                        mismatched++;
                        $display("FAIL frame_period: got %0d expected %0d", clk - lastVsFall, FRAME * CLK_DIV);
                    end
                end
                lastVsFall = clk;
            end
            prevVs = oVS;
            if (randEn) iEnable = ($urandom_range(7) != 0);
        end
        iEnable = 1'b1;
    endtask

    task automatic test_data_gating();
        int lit = 0;
        constMode = 1'b1;
        repeat (2 * CLK_DIV) @(negedge Clock);
        for (int i = 0; i < FRAME * CLK_DIV; i++) begin
            @(negedge Clock);
            if (lastTick) begin
                compared++;
                if (oRGB !== (oVideoActive ? 3'b101 : 3'b000)) begin
                    mismatched++;
                    $display("FAIL rgb_gating: got %b expected %b", oRGB, oVideoActive ? 3'b101 : 3'b000);
                end
                if (oRGB == 3'b101) lit++;
            end
        end
        compared++;
        if (lit != H_ACTIVE * V_ACTIVE) begin
            mismatched++;
            $display("FAIL lit_pixels: got %0d expected %0d", lit, H_ACTIVE * V_ACTIVE);
        end
        constMode = 1'b0;
        repeat (2 * CLK_DIV) @(negedge Clock);
    endtask

    task automatic test_enable_freeze();
        int target = 2 * H_TOTAL + FREEZE_H;
        bit found = 0;
        logic [VEC_W-1:0] snap;
        logic [ADDR_W-1:0] snapAddr;
        for (int i = 0; i < FRAME * CLK_DIV + 10 && !found; i++) begin
            @(negedge Clock);
            if (lastTick && pos == target) found = 1;
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("FAIL freeze_wait: got timeout expected pos %0d", target);
            return;
        end
        snap = outVec;
        snapAddr = oVmemAddress;
        compared++;
        if (snapAddr !== ADDR_W'(2 * H_ACTIVE + FREEZE_H)) begin
            mismatched++;
            $display("FAIL freeze_addr: got %0d expected %0d", snapAddr, 2 * H_ACTIVE + FREEZE_H);
        end
        iEnable = 1'b0;
        for (int i = 0; i < 37; i++) begin
            @(negedge Clock);
            compared++;
            if (outVec !== snap) begin
                mismatched++;
                $display("FAIL freeze_hold: got %h expected %h", outVec, snap);
            end
        end
        iEnable = 1'b1;
        for (int k = 1; k <= CLK_DIV; k++) begin
            @(negedge Clock);
            compared++;
            if (oVmemAddress !== ((k == CLK_DIV) ? snapAddr + ADDR_W'(1) : snapAddr)) begin
                mismatched++;
                $display("FAIL resume_addr clk%0d: got %0d expected %0d", k, oVmemAddress,
                         (k == CLK_DIV) ? snapAddr + ADDR_W'(1) : snapAddr);
            end
        end
    endtask

    task automatic test_reset_mid();
        repeat ($urandom_range(FRAME * CLK_DIV / 4, FRAME * CLK_DIV / 2)) @(negedge Clock);
        Reset = 1'b0;
        #1;
        compared++;
        if (outVec !== resetVec) begin
            mismatched++;
            $display("FAIL reset_async: got %h expected %h", outVec, resetVec);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            compared++;
            if (outVec !== resetVec) begin
                mismatched++;
                $display("FAIL reset_mid_hold: got %h expected %h", outVec, resetVec);
            end
        end
        Reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < MEM_SIZE; i++) vmem[i] = 3'($urandom);
        test_reset();
        test_frame(2 * FRAME * CLK_DIV + 50, 1'b0);
        test_data_gating();
        test_frame(FRAME * CLK_DIV, 1'b1);
        test_enable_freeze();
        test_frame(2 * H_TOTAL * CLK_DIV, 1'b0);
        test_reset_mid();
        test_frame(FRAME * CLK_DIV + 50, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
